opc7_sysbus: RTL and testbench
==============================

Name: opc7_sysbus

Overview:
- Bus responder for the OPC7 CPU bus: on-chip word RAM for program and data space (vpa/vda), a small I/O register file (vio), wait-state insertion through clken, and interrupt generation on int_b.
- Sits between the CPU and the board. It is the target end of the CPU's address/data/rnw/vpa/vda/vio protocol.

Parameters:
- AW, 12, RAM address width in words; RAM depth 2^AW; address bits above AW are ignored (aliasing).
- MEM_WAIT, 1, stall cycles per RAM access (vpa or vda); minimum 1.
- IO_WAIT, 2, stall cycles per I/O access (vio); minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  20  word address from CPU
- dout  in  32  CPU write data
- rnw  in  1  1=read, 0=write
- vpa  in  1  program fetch cycle
- vda  in  1  data memory cycle
- vio  in  1  I/O cycle
- ext_irq  in  1  external interrupt request, asynchronous, active-high level
- din  out  32  read data to CPU
- clken  out  1  CPU clock enable; 0 stalls the CPU
- int_b  out  2  interrupt requests, active-low; [0]=timer, [1]=external
- port_out  out  32  general output port register

Behaviour:
- Reset values: clken=1, din=0, int_b=2'b11, port_out=0, timer_reload=0, timer_count=0, timer_en=0, tpend=0, FSM=IDLE, wait counter=0, ext_irq synchroniser flops=0. RAM contents are not reset.
- access = vpa|vda|vio. vio has priority over vpa/vda. If vio and vda are both high, the cycle is treated as I/O.
- FSM states: IDLE and WAIT.
- IDLE:
  - If access=1, load the counter with (vio ? IO_WAIT : MEM_WAIT)-1, drive clken=0 combinationally, and go to WAIT.
  - If access=0, clken=1 and stay in IDLE.
- WAIT:
  - If counter!=0, clken=0 and decrement.
  - If counter==0, clken=1 for this cycle and return to IDLE. This cycle is the completion cycle.
- clken is a combinational function of FSM state, counter and access. It is high only in IDLE with no access, or in the WAIT completion cycle.
- Total access latency = wait parameter + 1 cycles, counted from the first cycle the access is presented to the completion edge.
- Read data: din is a register loaded every clk with the selected source, RAM[address[AW-1:0]] or the I/O register. Because the wait count is at least 1, din is stable and valid at the completion edge. The CPU holds address stable while clken=0.
- Writes: committed only at the completion edge (rnw=0 and completion cycle), so each write happens exactly once. Writes in non-completion cycles are ignored.
- I/O map (address[1:0]; address bits [19:2] are ignored for I/O):
  - 0 = timer_reload (RW).
  - 1 = timer_count (RO; writes ignored).
  - 2 = status/control: read {28'b0, irq_sync, tpend, 1'b0, timer_en}; write bit0 sets timer_en, write bit2=1 clears tpend.
  - 3 = port_out (RW).
- Timer, when timer_en=1, decrements every clk, independent of clken:
  - When timer_count==0, reload from timer_reload and set tpend.
  - timer_reload==0 gives tpend set every cycle.
  - If a write-1-to-clear of tpend and a timer expiry occur in the same cycle, the expiry wins and tpend stays 1.
  - A write to timer_reload also loads timer_count on the same edge.
- Interrupt outputs:
  - int_b[0] = ~tpend.
  - ext_irq passes through a 2-flop synchroniser; int_b[1] = ~irq_sync, a level with no latch.
- Reset asserted mid-access: the FSM returns to IDLE and clken=1 immediately (asynchronous). A pending write is dropped.

Optional Feature:
- OPC7_SYSBUS_TIMER_EN.
- Defined: timer and tpend exist as described above.
- Undefined:
  - Timer logic is removed.
  - I/O addresses 0 and 1 read 0 and writes to them are ignored.
  - The status read has tpend=0 and timer_en=0.
  - int_b[0] is tied to 1.

Test Plan:
- Reset release, vpa=1, address=0x00010, RAM[0x10] preloaded 0xDEADBEEF, MEM_WAIT=1 -> clken=0 for 1 cycle, then clken=1 with din=0xDEADBEEF at the completion edge.
- vda=1, rnw=0, address=0x00020, dout=0x12345678, then a read of the same address -> RAM[0x20] is written exactly once at completion; the read returns 0x12345678.
- vio=1 write of 0xA5A5A5A5 to address 3, IO_WAIT=2 -> clken low for 2 cycles; port_out=0xA5A5A5A5 after the completion edge; a readback via vio address 3 returns the same value.
- Write reload=4 to address 0, then write 0x1 to address 2 -> tpend sets and int_b[0] goes 0 five cycles after enable; repeats every 5 cycles; a write of 0x4 to address 2 returns int_b[0] to 1 until the next expiry.
- ext_irq pulsed high for 10 cycles -> int_b[1] goes 0 two cycles later and returns to 1 two cycles after ext_irq falls.
- reset asserted during WAIT of a write to 0x30 -> clken=1 immediately and RAM[0x30] is unchanged.

Source files
------------

// File: rtl/opc7_sysbus.sv
// opc7_sysbus -- target-side bus responder for the OPC7 CPU.
//
// Holds a 2^AW-word RAM shared by program (vpa) and data (vda) cycles, a
// four-entry I/O register file (vio), stretches every access with wait
// states through clken, and drives the active-low interrupt lines int_b.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   address   word address from the CPU (bits above AW alias in RAM)
//   dout      CPU write data
//   rnw       1 = read, 0 = write
//   vpa/vda   program fetch / data memory cycle
//   vio       I/O cycle (wins over vpa/vda)
//   ext_irq   asynchronous external interrupt level
//   din       registered read data to the CPU
//   clken     CPU clock enable, 0 stalls the CPU
//   int_b     active-low interrupts: [0] timer, [1] external
//   port_out  general purpose output register
//
// Build option: define OPC7_SYSBUS_TIMER_EN to include the interval timer.
// Without it, I/O addresses 0 and 1 read as zero, writes to them are
// dropped, the status register reports no timer, and int_b[0] stays high.

module opc7_sysbus #(
   parameter int AW       = 12,
   parameter int MEM_WAIT = 1,
   parameter int IO_WAIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] address,
   input  logic [31:0] dout,
   input  logic        rnw,
   input  logic        vpa,
   input  logic        vda,
   input  logic        vio,
   input  logic        ext_irq,
   output logic [31:0] din,
   output logic        clken,
   output logic [1:0]  int_b,
   output logic [31:0] port_out
);

   localparam int MAXW = (IO_WAIT > MEM_WAIT) ? IO_WAIT : MEM_WAIT;
   localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          access, complete;
   logic          wr_io, wr_mem;
   logic          irq_meta, irq_sync;
   logic [31:0]   io_rdata;
   logic [31:0]   timer_reload, timer_count;
   logic          timer_en, tpend;
   logic [31:0]   mem [2**AW];

   // Upper address bits only alias; fold them into a sink so they are
   // visibly consumed.
   logic unused_addr_hi;
   assign unused_addr_hi = ^address[19:AW];

   assign access = vpa | vda | vio;

   // ---------------- wait-state FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // held, which would otherwise infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      clken     = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               cnt_nxt   = vio ? CW'(IO_WAIT - 1) : CW'(MEM_WAIT - 1);
               state_nxt = WAIT;
            end else begin
               clken = 1'b1;
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               clken     = 1'b1;
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // The CPU may still be holding an access while reset is asserted;
      // clken must be released at once rather than after the FSM settles.
      if (reset) clken = 1'b1;
   end

   // Writes land only on the completion edge so each is committed once.
   assign wr_io  = complete & ~rnw & vio;
   assign wr_mem = complete & ~rnw & ~vio & (vpa | vda);

   // ---------------- RAM ----------------
   // NOTE: the RAM array has no reset; clearing it would prevent mapping
   // onto block memory and costs a full sweep of the array.
   always_ff @(posedge clk) begin
      if (wr_mem) mem[address[AW-1:0]] <= dout;
   end

   // Read data is refreshed every cycle; the address is stable through the
   // stall, so din is valid by the completion cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) din <= '0;
      else       din <= vio ? io_rdata : mem[address[AW-1:0]];
   end

   // ---------------- I/O registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_meta <= 1'b0;
         irq_sync <= 1'b0;
      end else begin
         irq_meta <= ext_irq;
         irq_sync <= irq_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             port_out <= '0;
      else if (wr_io && address[1:0] == 2'd3) port_out <= dout;
   end

`ifdef OPC7_SYSBUS_TIMER_EN
   logic expire;
   assign expire = timer_en && (timer_count == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_reload <= '0;
         timer_count  <= '0;
         timer_en     <= 1'b0;
         tpend        <= 1'b0;
      end else begin
         if (timer_en) begin
            if (expire) timer_count <= timer_reload;
            else        timer_count <= timer_count - 32'd1;
         end
         // A reload write restarts the count and overrides the decrement.
         if (wr_io && address[1:0] == 2'd0) begin
            timer_reload <= dout;
            timer_count  <= dout;
         end
         // timer_en is set-only; bit 0 written as 0 leaves it running.
         if (wr_io && address[1:0] == 2'd2 && dout[0]) timer_en <= 1'b1;
         // Expiry beats a simultaneous write-1-to-clear.
         if (expire)                                        tpend <= 1'b1;
         else if (wr_io && address[1:0] == 2'd2 && dout[2]) tpend <= 1'b0;
      end
   end
`else
   assign timer_reload = '0;
   assign timer_count  = '0;
   assign timer_en     = 1'b0;
   assign tpend        = 1'b0;
`endif

   always_comb begin
      io_rdata = '0;
      case (address[1:0])
         2'd0: io_rdata = timer_reload;
         2'd1: io_rdata = timer_count;
         2'd2: io_rdata = {28'b0, irq_sync, tpend, 1'b0, timer_en};
         2'd3: io_rdata = port_out;
         default: io_rdata = '0;
      endcase
   end

   assign int_b = {~irq_sync, ~tpend};

endmodule

// File: tb/tb_opc7_sysbus.sv
`timescale 1ns/1ps
module tb_opc7_sysbus;

   localparam int AW       = 12;
   localparam int MEM_WAIT = 1;
   localparam int IO_WAIT  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] address;
   logic [31:0] dout;
   logic        rnw, vpa, vda, vio, ext_irq;
   logic [31:0] din;
   logic        clken;
   logic [1:0]  int_b;
   logic [31:0] port_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_samp, last_done;

   // Reference state: RAM contents by aliased word address, port register.
   logic [31:0] ram_model [int];
   int          ram_keys [$];
   logic [31:0] port_model = '0;

   opc7_sysbus #(.AW(AW), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT)) dut (
      .clk(clk), .reset(reset), .address(address), .dout(dout), .rnw(rnw),
      .vpa(vpa), .vda(vda), .vio(vio), .ext_irq(ext_irq), .din(din),
      .clken(clken), .int_b(int_b), .port_out(port_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One complete bus cycle as the CPU would run it: present the access at a
   // negedge, hold it while clken is low, sample din in the completion cycle.
   task automatic bus(input logic pa, input logic da, input logic io, input logic rd,
                      input logic [19:0] a, input logic [31:0] wd, input string tag,
                      output logic [31:0] rdata);
      int stalls;
      @(negedge clk);
      address = a; dout = wd; rnw = rd; vpa = pa; vda = da; vio = io;
      stalls = 0;
      #1;
      while (!clken && stalls < 50) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      rdata     = din;
      last_samp = cyc;
      check({tag, "_stall"}, 32'(stalls), io ? 32'(IO_WAIT) : 32'(MEM_WAIT));
      @(negedge clk);
      last_done = cyc;
      vpa = 1'b0; vda = 1'b0; vio = 1'b0; rnw = 1'b1;
      if (!rd) begin
         if (io) begin
            if (a[1:0] == 2'd3) port_model = wd;
         end else begin
            ram_model[int'(a[AW-1:0])] = wd;
         end
      end
   endtask

   task automatic wr(input logic pa, input logic da, input logic io,
                     input logic [19:0] a, input logic [31:0] d, input string tag);
      logic [31:0] r;
      bus(pa, da, io, 1'b0, a, d, tag, r);
   endtask

   task automatic rd_chk(input logic pa, input logic da, input logic io,
                         input logic [19:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] r;
      bus(pa, da, io, 1'b1, a, 32'h0, tag, r);
      check(tag, r, exp);
   endtask

   initial begin
      logic [31:0] r, d;
      logic [19:0] a;
      int kind, key, e, c, fx, rise;

      reset = 1'b1; address = '0; dout = '0; rnw = 1'b1;
      vpa = 1'b0; vda = 1'b0; vio = 1'b0; ext_irq = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_clken", 32'(clken), 32'd1);
      check("rst_din", din, 32'd0);
      check("rst_int_b", 32'(int_b), 32'd3);
      check("rst_port", port_out, 32'd0);
      reset = 1'b0;

      // RAM: data write, program fetch readback, data readback, aliasing.
      wr(1'b0, 1'b1, 1'b0, 20'h00010, 32'hDEADBEEF, "ram10_wr");
      rd_chk(1'b1, 1'b0, 1'b0, 20'h00010, 32'hDEADBEEF, "fetch10");
      wr(1'b0, 1'b1, 1'b0, 20'h00020, 32'h12345678, "ram20_wr");
      rd_chk(1'b0, 1'b1, 1'b0, 20'h00020, 32'h12345678, "ram20_rd");
      rd_chk(1'b0, 1'b1, 1'b0, 20'h81020, 32'h12345678, "ram20_alias");

      // I/O port: vio+vda must be I/O, RAM at the same word untouched.
      wr(1'b0, 1'b1, 1'b0, 20'h00003, 32'h33333333, "ram3_wr");
      wr(1'b0, 1'b1, 1'b1, 20'hABCD3, 32'hA5A5A5A5, "port_wr");
      check("port_out", port_out, 32'hA5A5A5A5);
      rd_chk(1'b0, 1'b0, 1'b1, 20'h00003, 32'hA5A5A5A5, "port_rd");
      rd_chk(1'b0, 1'b1, 1'b0, 20'h00003, 32'h33333333, "ram3_kept");

      // External interrupt through the two-flop synchroniser.
      @(negedge clk);
      ext_irq = 1'b1;
      rise = cyc;
      @(negedge clk);
      check("irq_sync1", 32'(int_b[1]), 32'd1);
      @(negedge clk);
      check("irq_sync2", 32'(int_b[1]), 32'd0);
      rd_chk(1'b0, 1'b0, 1'b1, 20'h00002, 32'h8, "status_irq");
      while (cyc < rise + 10) @(negedge clk);
      ext_irq = 1'b0;
      @(negedge clk);
      check("irq_fall1", 32'(int_b[1]), 32'd0);
      @(negedge clk);
      check("irq_fall2", 32'(int_b[1]), 32'd1);

`ifdef OPC7_SYSBUS_TIMER_EN
      // Reload 4: expiries every 5 cycles counted from the enable edge e.
      wr(1'b0, 1'b0, 1'b1, 20'h00000, 32'd4, "reload_wr");
      rd_chk(1'b0, 1'b0, 1'b1, 20'h00000, 32'd4, "reload_rd");
      rd_chk(1'b0, 1'b0, 1'b1, 20'h00001, 32'd4, "count_idle");
      wr(1'b0, 1'b0, 1'b1, 20'h00002, 32'h1, "tmr_en");
      e = last_done;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check("tpend_rise", 32'(int_b[0]), (cyc >= e + 5) ? 32'd0 : 32'd1);
      end
      wr(1'b0, 1'b0, 1'b1, 20'h00001, 32'h99, "count_ro_wr");
      bus(1'b0, 1'b0, 1'b1, 1'b1, 20'h00001, 32'h0, "count_rd", r);
      // din in the sampling cycle shows the count as it stood after edge samp-1.
      check("count_rd", r, 32'(4 - ((last_samp - 1 - e) % 5)));
      rd_chk(1'b0, 1'b0, 1'b1, 20'h00002, 32'h5, "status_tmr");
      wr(1'b0, 1'b0, 1'b1, 20'h00002, 32'h4, "tpend_clr");
      c  = last_done;
      fx = e + 5 * ((c - e + 4) / 5);
      check("tpend_clr0", 32'(int_b[0]), (c == fx) ? 32'd0 : 32'd1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check("tpend_again", 32'(int_b[0]), (cyc >= fx) ? 32'd0 : 32'd1);
      end
      // Reload 0 expires every cycle, so a clear never wins.
      wr(1'b0, 1'b0, 1'b1, 20'h00000, 32'd0, "reload0_wr");
      wr(1'b0, 1'b0, 1'b1, 20'h00002, 32'h4, "clr_vs_exp");
      check("clr_vs_exp0", 32'(int_b[0]), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("reload0_pend", 32'(int_b[0]), 32'd0);
      end
`else
      wr(1'b0, 1'b0, 1'b1, 20'h00000, 32'h1234, "reload_wr");
      rd_chk(1'b0, 1'b0, 1'b1, 20'h00000, 32'h0, "reload_rd0");
      rd_chk(1'b0, 1'b0, 1'b1, 20'h00001, 32'h0, "count_rd0");
      wr(1'b0, 1'b0, 1'b1, 20'h00002, 32'h5, "tmr_en");
      rd_chk(1'b0, 1'b0, 1'b1, 20'h00002, 32'h0, "status_notmr");
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check("int0_idle", 32'(int_b[0]), 32'd1);
      end
`endif

      // Randomised RAM and port traffic against the reference model.
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         if (kind == 1 && ram_keys.size() == 0) kind = 0;
         d = $urandom;
         case (kind)
            0: begin
               key = $urandom_range(12'h100, 12'h10F);
               a   = {8'($urandom), 12'(key)};
               wr(1'b0, 1'b1, 1'b0, a, d, "rnd_mwr");
               ram_keys.push_back(key);
            end
            1: begin
               key = ram_keys[$urandom_range(0, ram_keys.size() - 1)];
               a   = {8'($urandom), 12'(key)};
               rd_chk(1'($urandom), 1'b1, 1'b0, a, ram_model[key], "rnd_mrd");
            end
            2: begin
               a = {18'($urandom), 2'd3};
               wr(1'b0, 1'($urandom), 1'b1, a, d, "rnd_pwr");
               check("rnd_port", port_out, port_model);
            end
            default: begin
               a = {18'($urandom), 2'd3};
               rd_chk(1'b0, 1'($urandom), 1'b1, a, port_model, "rnd_prd");
            end
         endcase
      end

      // Reset while an I/O write is stalled: clken releases at once.
      @(negedge clk);
      address = 20'h00003; dout = 32'hCAFEF00D; rnw = 1'b0; vio = 1'b1;
      @(negedge clk);
      #1;
      check("io_wait_stall", 32'(clken), 32'd0);
      reset = 1'b1;
      #1;
      check("rst_in_wait", 32'(clken), 32'd1);
      @(negedge clk);
      check("rst_port_clr", port_out, 32'd0);
      check("rst_int_b2", 32'(int_b), 32'd3);
      vio = 1'b0; rnw = 1'b1; reset = 1'b0;
      @(negedge clk);
      check("port_wr_dropped", port_out, 32'd0);

      // Reset in the completion cycle of a RAM write: the write is lost.
      wr(1'b0, 1'b1, 1'b0, 20'h00030, 32'h11111111, "ram30_wr");
      @(negedge clk);
      address = 20'h00030; dout = 32'h22222222; rnw = 1'b0; vda = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_wait_clken", 32'(clken), 32'd1);
      @(negedge clk);
      #1;
      check("rst_hold_clken", 32'(clken), 32'd1);
      check("rst_din2", din, 32'd0);
      vda = 1'b0; rnw = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rd_chk(1'b0, 1'b1, 1'b0, 20'h00030, 32'h11111111, "ram30_kept");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
